pe_array_ctrl: RTL and testbench
================================

PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

Interface
REQ-001 Parameter N, default 4: systolic array dimension (N rows x N columns of pe).
REQ-002 Parameter VCNT_W, default 8: width of vector-count fields.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  controller accepts command; high only in IDLE.
REQ-007 cmd_vectors  in  VCNT_W  number of input vectors to stream (0 legal).
REQ-008 cmd_reload_w  in  1  1 = load N weight rows before streaming; 0 = reuse resident weights.
REQ-009 w_valid  in  1  weight row available on the datapath.
REQ-010 w_ready  out  1  controller consumes a weight row this cycle if w_valid.
REQ-011 load_weight_row  out  N  one-hot per-row load_weight strobe to the array.
REQ-012 x_valid  in  1  input vector available.
REQ-013 x_ready  out  1  controller consumes an input vector this cycle if x_valid.
REQ-014 pe_start  out  1  start strobe to all pe (advance input pipeline).
REQ-015 x_bubble  out  1  datapath drives zeros into the array (drain).
REQ-016 busy  out  1  state != IDLE.
REQ-017 done  out  1  single-cycle completion pulse.

Function
REQ-018 FSM states IDLE, LOAD_W, STREAM, DRAIN, DONE; state is registered.
REQ-019 IDLE: cmd_valid&cmd_ready latches cmd_vectors to vec_left; next state is LOAD_W if cmd_reload_w=1, else STREAM if cmd_vectors!=0, else DONE.
REQ-020 LOAD_W: w_ready=1; on w_valid, load_weight_row = one-hot(row_cnt) combinationally in the same cycle and row_cnt increments; no strobe when w_valid=0.
REQ-021 LOAD_W exits after the N-th handshake (row_cnt = N-1): to STREAM if vec_left!=0, else DONE; row_cnt returns to 0.
REQ-022 Rows load in order 0..N-1; at most one bit of load_weight_row is set in any cycle.
REQ-023 STREAM: x_ready=1; pe_start = x_valid combinationally; each handshake decrements vec_left.
REQ-024 STREAM with x_valid=0: pe_start=0 and the array holds (stall), no timeout.
REQ-025 STREAM exits to DRAIN on the handshake that makes vec_left 0.
REQ-026 DRAIN: pe_start=1 and x_bubble=1 for exactly 2N-1 consecutive cycles (drain_cnt 0..2N-2), then DONE.
REQ-027 DONE: done=1 for one cycle, then IDLE; cmd_ready=0 during DONE.
REQ-028 w_ready, x_ready, pe_start, x_bubble, load_weight_row are 0 in every state other than the one that defines them.
REQ-029 Fully-streamed latency (w_valid, x_valid held 1, reload=1, V vectors): accept at cycle 0, loads cycles 1..N, vectors N+1..N+V, drain N+V+1..3N+V-1, done at 3N+V.
REQ-030 cmd_vectors = 2^VCNT_W-1 streams exactly that many vectors (no wrap in vec_left).
REQ-031 Inputs offered in the wrong state (w_valid in STREAM, x_valid in LOAD_W, cmd_valid while busy) are ignored, not consumed.

Reset
REQ-032 reset_n=0 forces, asynchronously, state=IDLE, row_cnt=0, vec_left=0, drain_cnt=0; all outputs 0 except cmd_ready, which is 1 after reset (IDLE).
REQ-033 Reset mid-operation (any state) abandons the command; no done pulse is produced.
REQ-034 First command is accepted on the first posedge with reset_n=1 and cmd_valid=1.

Structure
REQ-035 Package pe_ctrl_pkg holds the state enum (IDLE, LOAD_W, STREAM, DRAIN, DONE) and default N.
REQ-036 Single module, no sub-modules; counters inline; outputs decoded from state plus handshake inputs.

Verification
REQ-037 N=4, reload=1, vectors=3, w_valid/x_valid held 1 -> load_weight_row 0001,0010,0100,1000 cycles 1-4; pe_start cycles 5-7; x_bubble+pe_start cycles 8-14; done cycle 15.
REQ-038 reload=0, vectors=2, x_valid toggling 1,0,1 -> no load_weight_row strobe; pe_start 1,0,1; DRAIN 7 cycles; one done.
REQ-039 reload=1, vectors=0 -> 4 weight loads, then done with no pe_start at all.
REQ-040 w_valid gaps (1,0,0,1,1,1) during LOAD_W -> exactly 4 strobes, none in gap cycles; STREAM entered after 4th.
REQ-041 reset_n pulled low in STREAM after 1 of 5 vectors -> all outputs 0 immediately, cmd_ready=1 after release, no done; next command runs normally.
REQ-042 cmd_valid held 1 while busy and x_valid asserted during LOAD_W -> only one command accepted, no x_ready/pe_start until STREAM.

Source files
------------

// File: rtl/pe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pe_ctrl_pkg : shared state encoding and default array size for pe_array_ctrl
// Revision    : 1.0
// ============================================================================
package pe_ctrl_pkg;

  localparam int C_DEFAULT_N = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pe_array_ctrl.sv
`default_nettype none
// ============================================================================
// pe_array_ctrl : sequences weight load, input streaming and drain of an
//                 N x N systolic pe array
// Revision      : 1.0
// ============================================================================
module pe_array_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int N      = C_DEFAULT_N,
  parameter int VCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [VCNT_W-1:0] cmd_vectors,
  input  logic              cmd_reload_w,
  input  logic              w_valid,
  output logic              w_ready,
  output logic [N-1:0]      load_weight_row,
  input  logic              x_valid,
  output logic              x_ready,
  output logic              pe_start,
  output logic              x_bubble,
  output logic              busy,
  output logic              done
);

  localparam int C_ROW_W = (N > 1) ? $clog2(N) : 1;
  localparam int C_DRN_W = $clog2(2 * N);
  localparam logic [C_ROW_W-1:0] C_ROW_LAST = C_ROW_W'(N - 1);
  localparam logic [C_DRN_W-1:0] C_DRN_LAST = C_DRN_W'(2 * N - 2);
  localparam logic [N-1:0]       C_ONE      = N'(1);

  state_t              r_state;
  state_t              w_next_state;
  logic [C_ROW_W-1:0]  r_row_cnt;
  logic [VCNT_W-1:0]   r_vec_left;
  logic [C_DRN_W-1:0]  r_drain_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_row_cnt   <= '0;
      r_vec_left  <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE:   if (cmd_valid) r_vec_left <= cmd_vectors;
        LOAD_W: if (w_valid)
                  r_row_cnt <= (r_row_cnt == C_ROW_LAST) ? '0 : r_row_cnt + 1'b1;
        STREAM: if (x_valid) r_vec_left <= r_vec_left - 1'b1;
        DRAIN:  r_drain_cnt <= (r_drain_cnt == C_DRN_LAST) ? '0 : r_drain_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Handshake-qualified strobes are decoded combinationally so a row or
  // vector is consumed in the very cycle its valid is seen.
  always_comb begin
    w_next_state    = r_state;
    cmd_ready       = 1'b0;
    w_ready         = 1'b0;
    load_weight_row = '0;
    x_ready         = 1'b0;
    pe_start        = 1'b0;
    x_bubble        = 1'b0;
    done            = 1'b0;
    busy            = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_reload_w)            w_next_state = LOAD_W;
          else if (cmd_vectors != '0)  w_next_state = STREAM;
          else                         w_next_state = DONE;
        end
      end
      LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid) begin
          load_weight_row = C_ONE << r_row_cnt;
          if (r_row_cnt == C_ROW_LAST)
            w_next_state = (r_vec_left != '0) ? STREAM : DONE;
        end
      end
      STREAM: begin
        x_ready  = 1'b1;
        pe_start = x_valid;
        if (x_valid && (r_vec_left == VCNT_W'(1))) w_next_state = DRAIN;
      end
      DRAIN: begin
        pe_start = 1'b1;
        x_bubble = 1'b1;
        if (r_drain_cnt == C_DRN_LAST) w_next_state = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_array_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pe_array_ctrl : table-driven, hand-written and random checks of
//                    pe_array_ctrl against a counter-based reference model
// Revision         : 1.0
// ============================================================================
module tb_pe_array_ctrl;

  localparam int N      = 4;
  localparam int VCNT_W = 8;
  localparam int OW     = N + 7;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [VCNT_W-1:0] cmd_vectors = '0;
  logic              cmd_reload_w = 1'b0;
  logic              w_valid = 1'b0;
  logic              w_ready;
  logic [N-1:0]      load_weight_row;
  logic              x_valid = 1'b0;
  logic              x_ready;
  logic              pe_start;
  logic              x_bubble;
  logic              busy;
  logic              done;

  pe_array_ctrl #(.N(N), .VCNT_W(VCNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_vectors(cmd_vectors), .cmd_reload_w(cmd_reload_w),
    .w_valid(w_valid), .w_ready(w_ready), .load_weight_row(load_weight_row),
    .x_valid(x_valid), .x_ready(x_ready), .pe_start(pe_start),
    .x_bubble(x_bubble), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: work remaining per phase, consumed in priority order.
  bit m_active = 1'b0;
  int m_wrem = 0, m_wrow = 0, m_vec = 0, m_drain = 0;

  int st_loads, st_starts, st_bub, st_dones;
  bit last_done;

  typedef struct {
    logic        reload;
    logic [7:0]  vec;
    logic [15:0] wpat;
    logic [15:0] xpat;
    int          exp_loads;
    int          exp_starts;
    int          exp_bub;
    int          exp_lat;
  } vec_t;
  vec_t vt[7];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] expect_out(bit wv, bit xv);
    bit cr = 0, wr = 0, xr = 0, ps = 0, xb = 0, by = 0, dn = 0;
    logic [N-1:0] lw = '0;
    if (!m_active) cr = 1;
    else begin
      by = 1;
      if (m_wrem > 0) begin
        wr = 1;
        if (wv) lw = N'(1) << m_wrow;
      end else if (m_vec > 0) begin
        xr = 1;
        ps = xv;
      end else if (m_drain > 0) begin
        ps = 1;
        xb = 1;
      end else dn = 1;
    end
    return {cr, wr, lw, xr, ps, xb, by, dn};
  endfunction

  task automatic model_step(bit cv, logic [7:0] vec, bit rl, bit wv, bit xv);
    if (!m_active) begin
      if (cv) begin
        m_active = 1;
        m_wrem   = rl ? N : 0;
        m_wrow   = 0;
        m_vec    = int'(vec);
        m_drain  = (vec != 0) ? 2 * N - 1 : 0;
      end
    end else if (m_wrem > 0) begin
      if (wv) begin m_wrow++; m_wrem--; end
    end else if (m_vec > 0) begin
      if (xv) m_vec--;
    end else if (m_drain > 0) m_drain--;
    else m_active = 0;
  endtask

  task automatic cycle(bit cv, logic [7:0] vec, bit rl, bit wv, bit xv);
    logic [OW-1:0] act;
    @(negedge clk);
    cmd_valid = cv; cmd_vectors = vec; cmd_reload_w = rl;
    w_valid = wv; x_valid = xv;
    #1;
    act = {cmd_ready, w_ready, load_weight_row, x_ready, pe_start, x_bubble, busy, done};
    chk("outputs", int'(act), int'(expect_out(wv, xv)));
    st_loads  += (load_weight_row != '0) ? 1 : 0;
    st_starts += (pe_start && !x_bubble) ? 1 : 0;
    st_bub    += x_bubble ? 1 : 0;
    st_dones  += done ? 1 : 0;
    last_done  = done;
    model_step(cv, vec, rl, wv, xv);
  endtask

  task automatic run_entry(int i);
    int lat = -1;
    st_loads = 0; st_starts = 0; st_bub = 0; st_dones = 0;
    cycle(1'b1, vt[i].vec, vt[i].reload, 1'b0, 1'b0);
    for (int k = 1; k < 400 && lat < 0; k++) begin
      cycle(1'b1, vt[i].vec, vt[i].reload,
            (k <= 16) ? vt[i].wpat[k-1] : 1'b1,
            (k <= 16) ? vt[i].xpat[k-1] : 1'b1);
      if (last_done) lat = k;
    end
    chk($sformatf("loads[%0d]", i), st_loads, vt[i].exp_loads);
    chk($sformatf("starts[%0d]", i), st_starts, vt[i].exp_starts);
    chk($sformatf("bubbles[%0d]", i), st_bub, vt[i].exp_bub);
    chk($sformatf("latency[%0d]", i), lat, vt[i].exp_lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{1'b1, 8'd3,   16'hFFFF, 16'hFFFF, 4, 3,   7, 15};
    vt[1] = '{1'b0, 8'd2,   16'hFFFF, 16'hFFFD, 0, 2,   7, 11};
    vt[2] = '{1'b1, 8'd0,   16'hFFFF, 16'hFFFF, 4, 0,   0, 5};
    vt[3] = '{1'b1, 8'd1,   16'hFFF9, 16'hFFFF, 4, 1,   7, 15};
    vt[4] = '{1'b0, 8'd255, 16'hFFFF, 16'hFFFF, 0, 255, 7, 263};
    vt[5] = '{1'b0, 8'd1,   16'hFFFF, 16'hFFFF, 0, 1,   7, 9};
    vt[6] = '{1'b0, 8'd0,   16'hFFFF, 16'hFFFF, 0, 0,   0, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'({cmd_ready, w_ready, load_weight_row, x_ready,
                             pe_start, x_bubble, busy, done}),
        int'(expect_out(1'b0, 1'b0)));
    #1 reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_entry(i);
    cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Reset while streaming: abandon the command with no done pulse.
    st_dones = 0;
    cycle(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'd5, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1; w_valid = 1'b1; x_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("rst_outputs", int'({w_ready, load_weight_row, x_ready, pe_start,
                             x_bubble, busy, done}), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    m_active = 1'b0;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    chk("rst_no_done", st_dones, 0);
    run_entry(0);

    for (int k = 0; k < 1500; k++)
      cycle($urandom_range(0, 3) == 0, 8'($urandom_range(0, 9)),
            1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
